shared_memory_responder: RTL and testbench

Responder side of the shared-memory bus driven by each core's `shared_*` initiator ports. It accepts requests from up to `NUM_CORES` cores, grants one per cycle by round-robin arbitration, and services the winner from an internal synchronous single-port word RAM. Read data returns exactly one cycle after the grant, which matches the core's delayed data-select timing. It sits at the top level between the core array and the shared address region 0x4000–0xFFFF.

---
 rtl/shared_memory_responder.sv | 129 ++++++++++++
 tb/tb_shared_memory_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_memory_responder.sv
// Shared-memory responder: round-robin arbitration among NUM_CORES initiators in front of a
// single-port synchronous word RAM with one-cycle registered read data.
module shared_memory_responder #(
  parameter int unsigned NUM_CORES          = 4,
  parameter int unsigned SHARED_MEMORY_SIZE = 16384
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CORES-1:0]   core_request,
  input  logic [NUM_CORES-1:0]   core_wren,
  input  logic [NUM_CORES-1:0]   core_rden,
  input  logic [16*NUM_CORES-1:0] core_addr,
  input  logic [16*NUM_CORES-1:0] core_write_val,
  output logic [NUM_CORES-1:0]   core_ready,
  output logic [15:0]            shared_read_val,
  output logic                   grant_valid,
  output logic [3:0]             grant_id
);

  localparam int unsigned MEM_ADDR_WIDTH = $clog2(SHARED_MEMORY_SIZE);

  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] win_oh;
  logic                 win_found;
  logic [3:0]           win_id;

  logic [3:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0] rd_q;

  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_wren;
  logic        sel_rden;

  logic [MEM_ADDR_WIDTH-1:0] mem_idx;
  logic                      wr_en;
  logic                      rd_en;
  logic                      unused_addr;

  logic [15:0] mem [SHARED_MEMORY_SIZE];

  assign eligible = core_request & (core_wren | core_rden);

  // Two passes give the circular scan: first from rr_ptr upward, then from 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (!win_found && eligible[c] && (c >= int'({28'b0, rr_ptr_q}))) begin
        win_found = 1'b1;
        win_id    = 4'(c);
        win_oh    = '0;
        win_oh[c] = 1'b1;
      end
    end
    for (int c = 0; c < NUM_CORES; c++) begin
      if (!win_found && eligible[c]) begin
        win_found = 1'b1;
        win_id    = 4'(c);
        win_oh    = '0;
        win_oh[c] = 1'b1;
      end
    end
  end

  // One-hot select of the winner's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wren  = 1'b0;
    sel_rden  = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (win_oh[c]) begin
        sel_addr  = sel_addr  | core_addr[16*c +: 16];
        sel_wdata = sel_wdata | core_write_val[16*c +: 16];
        sel_wren  = sel_wren  | core_wren[c];
        sel_rden  = sel_rden  | core_rden[c];
      end
    end
  end

  // Reset level gates the grant so nothing is granted or written while held in reset.
  assign grant_valid = reset & win_found;
  assign core_ready  = reset ? win_oh : '0;
  assign grant_id    = grant_valid ? win_id : 4'd0;

  assign mem_idx     = sel_addr[MEM_ADDR_WIDTH-1:0];
  assign unused_addr = ^sel_addr;
  assign wr_en       = grant_valid & sel_wren;
  assign rd_en       = grant_valid & sel_rden & ~sel_wren;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      if (win_id == 4'(NUM_CORES - 1)) begin
        rr_ptr_d = 4'd0;
      end else begin
        rr_ptr_d = win_id + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= 4'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[mem_idx] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q <= 16'd0;
    end else if (rd_en) begin
      rd_q <= mem[mem_idx];
    end
  end

  assign shared_read_val = rd_q;

endmodule

// File: tb/tb_shared_memory_responder.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a behavioural model, a
// negedge monitor pops and compares against the responder outputs.
module tb_shared_memory_responder;

  localparam int N    = 4;
  localparam int SIZE = 16384;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     core_request;
  logic [N-1:0]     core_wren;
  logic [N-1:0]     core_rden;
  logic [16*N-1:0]  core_addr;
  logic [16*N-1:0]  core_write_val;
  logic [N-1:0]     core_ready;
  logic [15:0]      shared_read_val;
  logic             grant_valid;
  logic [3:0]       grant_id;

  shared_memory_responder #(
    .NUM_CORES          (N),
    .SHARED_MEMORY_SIZE (SIZE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .core_request    (core_request),
    .core_wren       (core_wren),
    .core_rden       (core_rden),
    .core_addr       (core_addr),
    .core_write_val  (core_write_val),
    .core_ready      (core_ready),
    .shared_read_val (shared_read_val),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] ready;
    logic         valid;
    logic [3:0]   id;
    logic [15:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_mem [SIZE];
  int          m_rr;
  logic [15:0] m_rd;
  logic [13:0] pool [16];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and record what the responder must show in that cycle.
  task automatic step(input logic rst_v, input logic [N-1:0] rq, input logic [N-1:0] wr,
                      input logic [N-1:0] rd, input logic [16*N-1:0] ad,
                      input logic [16*N-1:0] wd);
    exp_t e;
    int   win;
    int   idx;
    @(posedge clk);
    #1;
    reset          = rst_v;
    core_request   = rq;
    core_wren      = wr;
    core_rden      = rd;
    core_addr      = ad;
    core_write_val = wd;
    e = '0;
    if (!rst_v) begin
      m_rr = 0;
      m_rd = 16'd0;
      e.rd = 16'd0;
    end else begin
      e.rd = m_rd;
      win  = -1;
      for (int off = 0; off < N; off++) begin
        int c;
        c = (m_rr + off) % N;
        if (win < 0 && rq[c] && (wr[c] || rd[c])) win = c;
      end
      if (win >= 0) begin
        e.valid    = 1'b1;
        e.id       = 4'(win);
        e.ready[win] = 1'b1;
        idx = int'(ad[16*win +: 14]);
        if (wr[win]) m_mem[idx] = wd[16*win +: 16];
        else         m_rd       = m_mem[idx];
        m_rr = (win + 1) % N;
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("core_ready", 16'(core_ready), 16'(e.ready));
        chk("grant_valid", 16'(grant_valid), 16'(e.valid));
        chk("grant_id", 16'(grant_id), 16'(e.id));
        chk("shared_read_val", shared_read_val, e.rd);
      end
    end
  end

  initial begin : stim
    logic [16*N-1:0] ad;
    logic [16*N-1:0] wd;
    for (int j = 0; j < 16; j++) pool[j] = 14'(j * 1013 + 7);
    m_rr = 0;
    m_rd = 16'd0;
    reset          = 1'b1;
    core_request   = '0;
    core_wren      = '0;
    core_rden      = '0;
    core_addr      = '0;
    core_write_val = '0;
    #1 reset = 1'b0;
    step(1'b0, '0, '0, '0, '0, '0);
    step(1'b0, '0, '0, '0, '0, '0);

    // Fill the address pool through core 0.
    for (int j = 0; j < 16; j++) begin
      ad = '0;
      wd = '0;
      ad[15:0] = {2'b01, pool[j]};
      wd[15:0] = 16'($urandom);
      step(1'b1, 4'b0001, 4'b0001, 4'b0000, ad, wd);
    end

    // Held in reset with every core writing: nothing granted, RAM untouched.
    for (int i = 0; i < N; i++) begin
      ad[16*i +: 16] = {2'b01, pool[i]};
      wd[16*i +: 16] = 16'hDEAD;
    end
    for (int k = 0; k < 3; k++) step(1'b0, 4'hF, 4'hF, 4'h0, ad, wd);
    for (int k = 0; k < 5; k++) step(1'b1, 4'hF, 4'h0, 4'hF, ad, wd);

    // Core 2 write then read of 0x4010.
    ad = '0;
    wd = '0;
    ad[47:32] = 16'h4010;
    wd[47:32] = 16'hBEEF;
    step(1'b1, 4'b0100, 4'b0100, 4'b0000, ad, wd);
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, ad, wd);
    step(1'b1, '0, '0, '0, ad, wd);
    step(1'b1, '0, '0, '0, ad, wd);

    // All cores reading continuously.
    for (int i = 0; i < N; i++) ad[16*i +: 16] = {2'b10, pool[i + 4]};
    for (int k = 0; k < 9; k++) step(1'b1, 4'hF, 4'h0, 4'hF, ad, '0);
    step(1'b1, '0, '0, '0, ad, '0);

    // Pointer to 3 via a lone core 2 grant, then cores 3 and 0 contend across the wrap.
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, ad, '0);
    for (int k = 0; k < 4; k++) step(1'b1, 4'b1001, 4'b0000, 4'b1001, ad, '0);

    // Request with no enable is never granted.
    step(1'b1, 4'b0010, 4'b0000, 4'b0000, ad, '0);
    step(1'b1, 4'b0010, 4'b0000, 4'b0000, ad, '0);
    step(1'b1, 4'b0110, 4'b0000, 4'b0100, ad, '0);
    step(1'b1, 4'b0110, 4'b0000, 4'b0100, ad, '0);

    // Write with both enables at 0x4005, read back through alias 0x8005.
    ad = '0;
    wd = '0;
    ad[15:0] = {2'b01, pool[9]};
    step(1'b1, 4'b0001, 4'b0000, 4'b0001, ad, wd);
    ad[15:0] = 16'h4005;
    wd[15:0] = 16'h1234;
    step(1'b1, 4'b0001, 4'b0001, 4'b0001, ad, wd);
    ad[15:0] = 16'h8005;
    step(1'b1, 4'b0001, 4'b0000, 4'b0001, ad, wd);
    step(1'b1, '0, '0, '0, ad, wd);

    // Random traffic over the pool with aliased upper bits and occasional reset.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        ad[16*i +: 16] = {2'($urandom), pool[$urandom_range(0, 15)]};
        wd[16*i +: 16] = 16'($urandom);
      end
      step(1'($urandom_range(0, 59) != 0), 4'($urandom), 4'($urandom), 4'($urandom), ad, wd);
    end
    step(1'b1, '0, '0, '0, ad, wd);

    @(negedge clk);
    #1;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
